// File: rtl/clk_edge_meter.sv
// clk_edge_meter: synchronises a slow asynchronous square wave into the Clk
// domain, emits rise/fall ticks and measures high, low and period lengths
// in Clk cycles. Flags a stalled input when no edge arrives within TIMEOUT.
module clk_edge_meter #(
  parameter int unsigned CNT_W   = 29,
  parameter int unsigned TIMEOUT = 200000000
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             SigIn,
  output logic             RiseTick,
  output logic             FallTick,
  output logic [CNT_W-1:0] HighCnt,
  output logic [CNT_W-1:0] LowCnt,
  output logic [CNT_W:0]   PeriodCnt,
  output logic             Valid,
  output logic             Stalled
);

  typedef enum logic [1:0] {
    WAIT_RISE,
    MEAS_HIGH,
    MEAS_LOW
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic             s1;
  logic             s2;
  logic             sp;
  logic             rise;
  logic             fall;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] hi_tmp;
  logic             at_timeout;
  logic             capture_hi;
  logic             publish;
  logic             set_stall;
  logic             clr_stall;

  assign rise       = s2 & ~sp;
  assign fall       = ~s2 & sp;
  assign at_timeout = (cnt == TIMEOUT_C) && !rise && !fall;

  // Two-flop synchroniser plus history flop for edge detection
  always_ff @(posedge Clk) begin
    if (Rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      sp <= 1'b0;
    end else begin
      s1 <= SigIn;
      s2 <= s1;
      sp <= s2;
    end
  end

  // Registered edge ticks
  always_ff @(posedge Clk) begin
    if (Rst) begin
      RiseTick <= 1'b0;
      FallTick <= 1'b0;
    end else begin
      RiseTick <= rise;
      FallTick <= fall;
    end
  end

  // Cycle counter: restarts at 1 on every edge, saturates instead of wrapping
  always_ff @(posedge Clk) begin
    if (Rst) begin
      cnt <= '0;
    end else if (rise || fall) begin
      cnt <= ONE_C;
    end else if (cnt != '1) begin
      cnt <= cnt + ONE_C;
    end
  end

  // Measurement state register
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state <= WAIT_RISE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath strobes; an edge always beats the timeout
  always_comb begin
    state_nxt  = state;
    capture_hi = 1'b0;
    publish    = 1'b0;
    set_stall  = 1'b0;
    clr_stall  = 1'b0;
    case (state)
      WAIT_RISE: begin
        if (rise) begin
          state_nxt = MEAS_HIGH;
          clr_stall = 1'b1;
        end
      end
      MEAS_HIGH: begin
        if (fall) begin
          capture_hi = 1'b1;
          state_nxt  = MEAS_LOW;
        end else if (at_timeout) begin
          set_stall = 1'b1;
          state_nxt = WAIT_RISE;
        end
      end
      MEAS_LOW: begin
        if (rise) begin
          publish   = 1'b1;
          state_nxt = MEAS_HIGH;
        end else if (at_timeout) begin
          set_stall = 1'b1;
          state_nxt = WAIT_RISE;
        end
      end
      default: state_nxt = WAIT_RISE;
    endcase
  end

  // Measurement registers, Valid pulse and stall flag
  always_ff @(posedge Clk) begin
    if (Rst) begin
      hi_tmp    <= '0;
      HighCnt   <= '0;
      LowCnt    <= '0;
      PeriodCnt <= '0;
      Valid     <= 1'b0;
      Stalled   <= 1'b0;
    end else begin
      Valid <= publish;
      if (capture_hi) begin
        hi_tmp <= cnt;
      end
      if (publish) begin
        HighCnt   <= hi_tmp;
        LowCnt    <= cnt;
        PeriodCnt <= {1'b0, hi_tmp} + {1'b0, cnt};
      end
      if (set_stall) begin
        Stalled <= 1'b1;
      end else if (clr_stall) begin
        Stalled <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_edge_meter.sv
// Scoreboard bench for clk_edge_meter: stimulus pushes expected
// measurements, a negedge monitor pops them on each Valid.
module tb_clk_edge_meter;

  localparam int unsigned CNT_W   = 12;
  localparam int unsigned TIMEOUT = 20;

  typedef struct packed {
    logic [CNT_W-1:0] hi;
    logic [CNT_W-1:0] lo;
    logic [CNT_W:0]   per;
  } meas_t;

  logic             Clk = 1'b0;
  logic             Rst;
  logic             SigIn;
  logic             RiseTick;
  logic             FallTick;
  logic [CNT_W-1:0] HighCnt;
  logic [CNT_W-1:0] LowCnt;
  logic [CNT_W:0]   PeriodCnt;
  logic             Valid;
  logic             Stalled;

  meas_t exp_q[$];
  meas_t model;
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  bit    rst_q    = 1'b0;
  bit    started  = 1'b0;

  int    rises_since_rst = 0;
  bit    valid_seen      = 1'b0;
  bit    have_prev       = 1'b0;
  int    last_rise_cyc   = 0;
  int    last_valid_cyc  = 0;
  logic [CNT_W:0] last_per = '0;
  bit    prev_stalled    = 1'b0;
  int    stall_events    = 0;
  int    first_rise_cyc  = -1;
  int    first_hi_cyc    = 0;

  always #5 Clk = ~Clk;

  clk_edge_meter #(
    .CNT_W  (CNT_W),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .Clk      (Clk),
    .Rst      (Rst),
    .SigIn    (SigIn),
    .RiseTick (RiseTick),
    .FallTick (FallTick),
    .HighCnt  (HighCnt),
    .LowCnt   (LowCnt),
    .PeriodCnt(PeriodCnt),
    .Valid    (Valid),
    .Stalled  (Stalled)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic hold(input logic v, input int n);
    SigIn = v;
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic push(input int h, input int l);
    meas_t m;
    m.hi  = CNT_W'(h);
    m.lo  = CNT_W'(l);
    m.per = (CNT_W + 1)'(h + l);
    exp_q.push_back(m);
  endtask

  always @(posedge Clk) begin
    cyc++;
    rst_q   = Rst;
    started = 1'b1;
  end

  // Monitor: outputs hold between Valids, change only to scoreboard values
  always @(negedge Clk) begin
    meas_t e;
    if (started) begin
      if (rst_q) begin
        check("rst_rise",   64'(RiseTick),  64'(0));
        check("rst_fall",   64'(FallTick),  64'(0));
        check("rst_valid",  64'(Valid),     64'(0));
        check("rst_stall",  64'(Stalled),   64'(0));
        check("rst_high",   64'(HighCnt),   64'(0));
        check("rst_low",    64'(LowCnt),    64'(0));
        check("rst_period", 64'(PeriodCnt), 64'(0));
        model           = '0;
        rises_since_rst = 0;
        valid_seen      = 1'b0;
        have_prev       = 1'b0;
        prev_stalled    = 1'b0;
        first_rise_cyc  = -1;
      end else begin
        check("tick_excl", 64'(RiseTick & FallTick), 64'(0));
        if (RiseTick) begin
          rises_since_rst++;
          last_rise_cyc = cyc;
          if (first_rise_cyc < 0) first_rise_cyc = cyc;
        end
        if (Valid) begin
          check("valid_with_rise", 64'(RiseTick), 64'(1));
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_valid: got Valid=1 with High=%0d Low=%0d, expected no Valid", HighCnt, LowCnt);
          end else begin
            e = exp_q.pop_front();
            check("valid_high",   64'(HighCnt),   64'(e.hi));
            check("valid_low",    64'(LowCnt),    64'(e.lo));
            check("valid_period", 64'(PeriodCnt), 64'(e.per));
            if (!valid_seen) check("first_valid_rise_no", 64'(rises_since_rst), 64'(2));
            if (have_prev && e.per == last_per)
              check("valid_interval", 64'(cyc - last_valid_cyc), 64'(e.per));
            model          = e;
            last_per       = e.per;
            last_valid_cyc = cyc;
            have_prev      = 1'b1;
            valid_seen     = 1'b1;
          end
        end else begin
          check("hold_high",   64'(HighCnt),   64'(model.hi));
          check("hold_low",    64'(LowCnt),    64'(model.lo));
          check("hold_period", 64'(PeriodCnt), 64'(model.per));
        end
        if (Stalled && !prev_stalled) begin
          stall_events++;
          check("stall_delay", 64'(cyc - last_rise_cyc), 64'(TIMEOUT));
          have_prev = 1'b0;
        end
        if (!Stalled && prev_stalled) begin
          check("stall_clear_rise",    64'(RiseTick), 64'(1));
          check("stall_clear_novalid", 64'(Valid),    64'(0));
        end
        prev_stalled = Stalled;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of stimulus, expected completion");
    $fatal(1, "watchdog expired");
  end

  // Stimulus: each period's expected result is pushed after its low phase
  initial begin
    Rst   = 1'b1;
    SigIn = 1'b0;
    @(posedge Clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      SigIn = ~SigIn;
      @(posedge Clk);
      #1;
    end
    Rst = 1'b0;
    hold(1'b0, 4);

    first_hi_cyc = cyc;
    for (int i = 0; i < 5; i++) begin
      hold(1'b1, 2); hold(1'b0, 2); push(2, 2);
    end
    check("first_rise_latency", 64'(first_rise_cyc), 64'(first_hi_cyc + 3));

    for (int i = 0; i < 3; i++) begin
      hold(1'b1, 7); hold(1'b0, 3); push(7, 3);
    end
    for (int i = 0; i < 3; i++) begin
      hold(1'b1, 1); hold(1'b0, 1); push(1, 1);
    end

    hold(1'b1, 30);
    check("stalled_set", 64'(Stalled), 64'(1));
    check("stall_count_a", 64'(stall_events), 64'(1));
    hold(1'b0, 5);
    check("stalled_ignore_fall", 64'(Stalled), 64'(1));
    hold(1'b1, 4);
    check("stalled_cleared", 64'(Stalled), 64'(0));
    hold(1'b0, 6); push(4, 6);

    hold(1'b1, 20); hold(1'b0, 3); push(20, 3);
    hold(1'b1, 3);
    hold(1'b0, 4);

    Rst = 1'b1;
    repeat (2) @(posedge Clk);
    #1;
    Rst = 1'b0;
    hold(1'b0, 3);
    hold(1'b1, 5); hold(1'b0, 5); push(5, 5);
    hold(1'b1, 5); hold(1'b0, 5); push(5, 5);
    hold(1'b1, 2); hold(1'b0, 2);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) begin
      @(posedge Clk);
      #1;
    end
    check("queue_drained", 64'(exp_q.size()), 64'(0));
    check("stall_count_final", 64'(stall_events), 64'(1));
    check("no_stall_end", 64'(Stalled), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
